// File: rtl/acia_pkg.sv
// Shared register map, status layout and control bit positions for the ACIA receive path.
package acia_pkg;

    localparam int unsigned DW = 8;

    // Register offsets selected by rs
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // Status register bit positions
    localparam int unsigned ST_RXNE = 0;
    localparam int unsigned ST_FULL = 2;
    localparam int unsigned ST_FERR = 3;
    localparam int unsigned ST_OVR  = 4;
    localparam int unsigned ST_RXEN = 5;
    localparam int unsigned ST_IE   = 6;
    localparam int unsigned ST_IRQ  = 7;

    // Control register bit positions
    localparam int unsigned CTL_RXEN  = 0;
    localparam int unsigned CTL_IE    = 1;
    localparam int unsigned CTL_FLUSH = 7;

    typedef struct packed {
        logic irq;
        logic ie;
        logic rx_en;
        logic ovr;
        logic ferr;
        logic full;
        logic rsvd;
        logic rxne;
    } stat_t;

endpackage

// File: rtl/acia_fifo.sv
// Single-clock byte FIFO with push/pop/flush; head and next count exposed combinationally.
module acia_fifo
    import acia_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   head_c,
    output logic [AW:0]     count,
    output logic [AW:0]     count_next_c,
    output logic            full_c,
    output logic            empty_c
);

    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr_next;
    logic [AW-1:0] rptr_next;
    logic          push_ok;
    logic          pop_ok;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rptr];

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle
    always_comb begin
        pop_ok       = pop & ~empty_c;
        push_ok      = push & (~full_c | pop_ok);
        wptr_next    = wptr;
        rptr_next    = rptr;
        count_next_c = count;
        if (flush) begin
            wptr_next    = '0;
            rptr_next    = '0;
            count_next_c = '0;
        end else begin
            if (push_ok) wptr_next = wptr + AW'(1);
            if (pop_ok)  rptr_next = rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next_c = count + CW'(1);
                2'b01:   count_next_c = count - CW'(1);
                default: count_next_c = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            count <= count_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/acia_rx_ctrl.sv
// Receive-side controller: receiver gating, byte FIFO, sticky error flags, CPU registers and IRQ.
module acia_rx_ctrl
    import acia_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned IRQ_LVL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] rx_dat,
    input  logic          rx_stb,
    input  logic          rx_err,
    output logic          rx_reset_n,
    input  logic          cs,
    input  logic          we,
    input  logic          rs,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          irq
);

    localparam int unsigned CW = AW + 1;

    logic          ctl_wr;
    logic          data_rd;
    logic          stat_rd;
    logic          flush;
    logic          push;
    logic          rx_en;
    logic          ie;
    logic          ovr;
    logic          ferr;
    logic          rx_err_d;
    logic          rx_en_next;
    logic          ie_next;
    logic          ovr_next;
    logic          ferr_next;
    logic          ovr_set;
    logic          ferr_set;
    logic          irq_next;
    logic [DW-1:0] dout_next;
    logic [DW-1:0] head_c;
    logic [AW:0]   count;
    logic [AW:0]   count_next_c;
    logic          full_c;
    logic          empty_c;
    stat_t         stat;
    logic          unused_din;

    assign unused_din = ^din[CTL_FLUSH-1:CTL_IE+1];

    assign ctl_wr  = cs & we & (rs == REG_STAT);
    assign data_rd = cs & ~we & (rs == REG_DATA);
    assign stat_rd = cs & ~we & (rs == REG_STAT);
    assign flush   = ctl_wr & din[CTL_FLUSH];
    assign push    = rx_stb & rx_en & ~flush;

    acia_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (data_rd),
        .flush        (flush),
        .wdata        (rx_dat),
        .head_c       (head_c),
        .count        (count),
        .count_next_c (count_next_c),
        .full_c       (full_c),
        .empty_c      (empty_c)
    );

    always_comb begin
        stat       = '0;
        stat.irq   = irq;
        stat.ie    = ie;
        stat.rx_en = rx_en;
        stat.ovr   = ovr;
        stat.ferr  = ferr;
        stat.full  = full_c;
        stat.rxne  = ~empty_c;
    end

    // Error flag sets take priority over the clear caused by a status read
    always_comb begin
        rx_en_next = rx_en;
        ie_next    = ie;
        dout_next  = dout;
        ovr_set    = push & full_c & ~data_rd;
        ferr_set   = rx_err & ~rx_err_d & rx_en;
        ovr_next   = ovr_set | (ovr & ~stat_rd);
        ferr_next  = ferr_set | (ferr & ~stat_rd);
        if (ctl_wr) begin
            rx_en_next = din[CTL_RXEN];
            ie_next    = din[CTL_IE];
        end
        if (data_rd) begin
            dout_next = empty_c ? '0 : head_c;
        end else if (stat_rd) begin
            dout_next = stat;
        end
        irq_next = ie_next & ((count_next_c >= CW'(IRQ_LVL)) | ovr_next | ferr_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_en      <= 1'b0;
            ie         <= 1'b0;
            ovr        <= 1'b0;
            ferr       <= 1'b0;
            rx_err_d   <= 1'b0;
            dout       <= '0;
            irq        <= 1'b0;
            rx_reset_n <= 1'b0;
        end else begin
            rx_en      <= rx_en_next;
            ie         <= ie_next;
            ovr        <= ovr_next;
            ferr       <= ferr_next;
            rx_err_d   <= rx_err;
            dout       <= dout_next;
            irq        <= irq_next;
            rx_reset_n <= rx_en;
        end
    end

endmodule

// File: tb/tb_acia_rx_ctrl.sv
// Scoreboard bench for acia_rx_ctrl: reads queue expected bus data, a monitor compares dout.
module tb_acia_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       rx_reset_n;
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    int total = 0;
    int bad   = 0;
    int rd_id = 0;

    logic [7:0] exp_q [$];
    int         id_q  [$];
    bit         rd_seen = 0;

    always #5 clk = ~clk;

    acia_rx_ctrl #(.DEPTH(8), .AW(3), .IRQ_LVL(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_dat     (rx_dat),
        .rx_stb     (rx_stb),
        .rx_err     (rx_err),
        .rx_reset_n (rx_reset_n),
        .cs         (cs),
        .we         (we),
        .rs         (rs),
        .din        (din),
        .dout       (dout),
        .irq        (irq)
    );

    // Note which edges carried a bus read
    always @(posedge clk) rd_seen = cs && !we && !reset;

    // Monitor: every read edge presents a value on dout that must match the queue head
    always @(negedge clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dout unexpected read got=%h (no expectation queued)", dout);
            end else begin
                logic [7:0] e;
                int         id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL dout read#%0d got=%h want=%h", id, dout, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic r, input logic [7:0] d,
                       input logic stb, input logic [7:0] dat);
        cs     = c;
        we     = w;
        rs     = r;
        din    = d;
        rx_stb = stb;
        rx_dat = dat;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rx(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, b);
    endtask

    task automatic wr_ctl(input logic [7:0] v);
        cyc(1'b1, 1'b1, 1'b1, v, 1'b0, 8'h00);
    endtask

    task automatic expect_rd(input logic [7:0] e);
        exp_q.push_back(e);
        id_q.push_back(rd_id);
        rd_id++;
    endtask

    task automatic rd_data(input logic [7:0] e);
        expect_rd(e);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rd_stat(input logic [7:0] e);
        expect_rd(e);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        reset  = 1'b1;
        rx_err = 1'b0;
        cs = 0; we = 0; rs = 0; din = 0; rx_stb = 0; rx_dat = 0;
        repeat (2) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_rx_reset_n", {7'd0, rx_reset_n}, 8'h00);
        reset = 1'b0;

        // Disabled receiver ignores strobes
        rd_stat(8'h00);
        rx(8'h55);
        rx(8'h56);
        rd_stat(8'h00);
        rd_data(8'h00);

        // Enable with interrupts, three bytes in order
        wr_ctl(8'h03);
        idle();
        check("rx_reset_n_enabled", {7'd0, rx_reset_n}, 8'h01);
        rx(8'h41);
        check("irq_after_first_push", {7'd0, irq}, 8'h01);
        rx(8'h42);
        rx(8'h43);
        rd_stat(8'hE1);
        rd_data(8'h41);
        rd_data(8'h42);
        rd_data(8'h43);
        check("irq_after_drain", {7'd0, irq}, 8'h00);
        rd_stat(8'h60);
        rd_data(8'h00);

        // Overrun: ninth byte dropped, flag sticky until status read
        for (int i = 0; i < 9; i++) rx(8'(8'h10 + i));
        rd_stat(8'hF5);
        rd_stat(8'hE5);

        // Full FIFO with simultaneous push and pop: no overrun
        expect_rd(8'h10);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h19);
        rd_stat(8'hE5);
        for (int i = 1; i < 8; i++) rd_data(8'(8'h10 + i));
        rd_data(8'h19);
        rd_stat(8'h60);

        // Framing error arriving during a status read survives the clear
        rx_err = 1'b1;
        rd_stat(8'h60);
        check("irq_on_ferr", {7'd0, irq}, 8'h01);
        rd_stat(8'hE8);
        rd_stat(8'h60);
        rx_err = 1'b0;
        idle();

        // Flush coincident with a received byte
        for (int i = 0; i < 4; i++) rx(8'(8'h21 + i));
        check("irq_before_flush", {7'd0, irq}, 8'h01);
        cyc(1'b1, 1'b1, 1'b1, 8'h83, 1'b1, 8'h25);
        check("irq_after_flush", {7'd0, irq}, 8'h00);
        rd_stat(8'h60);
        check("rx_reset_n_after_flush", {7'd0, rx_reset_n}, 8'h01);
        rd_data(8'h00);

        // Disable: receiver back in reset, strobes ignored
        wr_ctl(8'h00);
        rx(8'h77);
        check("rx_reset_n_disabled", {7'd0, rx_reset_n}, 8'h00);
        rd_stat(8'h00);
        rd_data(8'h00);

        idle();
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
